window_peak_detector: RTL and testbench
=======================================

WINDOW_PEAK_DETECTOR -- requirements
Module: window_peak_detector

Interface
REQ-001 SHALL provide parameter DW, default 16: I/Q sample width, bits.
REQ-002 SHALL provide parameter MW, default 33: magnitude width, bits, unsigned.
REQ-003 SHALL provide parameter WIN, default 32: window length in accepted samples, legal range 1..1024.
REQ-004 SHALL provide parameter IDXW, default 5: index width; SHALL satisfy 2^IDXW >= WIN.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  in  1  sample accepted this cycle when high.
REQ-008 SHALL have ports in_mag  in  MW; in_i, in_q  in  DW each: sample magnitude and I/Q.
REQ-009 SHALL have port restart  in  1  abort current window, realign to index 0.
REQ-010 SHALL have port out_valid  out  1  one-cycle pulse, window result ready.
REQ-011 SHALL have ports out_mag  out  MW; out_i, out_q  out  DW each: peak magnitude and I/Q.
REQ-012 SHALL have port out_idx  out  IDXW  position of peak within window, 0-based.
REQ-013 SHALL have port win_pos  out  IDXW  index the next accepted sample will take.

Function
REQ-014 SHALL count accepted samples 0..WIN-1 in win_pos, wrapping to 0 after WIN-1.
REQ-015 Sample at index 0 SHALL load running max (mag, I, Q, idx) unconditionally.
REQ-016 Sample at index >0 SHALL replace running max only if in_mag > max, unsigned strict compare; ties keep earliest index.
REQ-017 Cycles with in_valid low SHALL change no state.
REQ-018 Accepting the index WIN-1 sample SHALL assert out_valid exactly one cycle later (latency 1), with out_* reflecting the max including that sample.
REQ-019 out_mag/out_i/out_q/out_idx SHALL hold until the next out_valid.
REQ-020 Back-to-back windows SHALL be supported with no dead cycle: in_valid may be high every cycle.
REQ-021 restart high SHALL discard the partial window, produce no out_valid for it, and set win_pos to 0.
REQ-022 restart and in_valid high together SHALL take that sample as index 0 of the new window.
REQ-023 restart on the cycle of the index WIN-1 sample SHALL take priority: no out_valid, sample becomes index 0.
REQ-024 WIN=1 SHALL emit every accepted sample with out_idx=0.

Reset
REQ-025 reset SHALL take priority over restart and in_valid.
REQ-026 On reset: out_valid=0, out_mag=0, out_i=0, out_q=0, out_idx=0, win_pos=0, running max cleared.
REQ-027 reset mid-window SHALL discard the partial window with no out_valid.

Configuration
REQ-028 Macro WINDOW_PEAK_THRESH_EN defined SHALL add input thresh (MW) and output out_hit (1).
REQ-029 With it, out_hit SHALL update with out_valid to (peak mag >= thresh sampled on the WIN-1 sample cycle), reset value 0, held otherwise.
REQ-030 Without it, neither port SHALL exist and no comparator logic SHALL be synthesised.

Verification
REQ-031 WIN=4, mags 5,9,3,7 contiguous -> out_valid one cycle after 4th, out_mag=9, out_idx=1, I/Q of 2nd sample.
REQ-032 WIN=4, mags 6,6,2,6 -> out_mag=6, out_idx=0 (tie keeps earliest).
REQ-033 WIN=4, mags 1,8 then restart with mag 4, then 2,3,1 -> single out_valid, out_mag=4, out_idx=0.
REQ-034 WIN=4, 12 samples with in_valid gaps of 0-3 cycles -> exactly 3 out_valid pulses, peaks correct per window.
REQ-035 reset asserted after 2 of 4 samples -> no out_valid; outputs 0; next 4 samples form a fresh window.
REQ-036 WINDOW_PEAK_THRESH_EN, thresh=9: window peak 9 -> out_hit=1; next window peak 8 -> out_hit=0.

Source files
------------

// File: rtl/window_peak_detector.sv
// Tracks the largest-magnitude sample (with its I/Q and index) over fixed windows of WIN accepted samples.
// Optional threshold flag on each window result when WINDOW_PEAK_THRESH_EN is defined.
module window_peak_detector #(
   parameter int unsigned DW   = 16,
   parameter int unsigned MW   = 33,
   parameter int unsigned WIN  = 32,
   parameter int unsigned IDXW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [MW-1:0]   in_mag,
   input  logic [DW-1:0]   in_i,
   input  logic [DW-1:0]   in_q,
   input  logic            restart,
   output logic            out_valid,
   output logic [MW-1:0]   out_mag,
   output logic [DW-1:0]   out_i,
   output logic [DW-1:0]   out_q,
   output logic [IDXW-1:0] out_idx,
   output logic [IDXW-1:0] win_pos
`ifdef WINDOW_PEAK_THRESH_EN
   ,
   input  logic [MW-1:0]   thresh,
   output logic            out_hit
`endif
);

   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WIN - 1);
   localparam logic [IDXW-1:0] AFTER_RST = (WIN == 1) ? '0 : IDXW'(1);

   logic [IDXW-1:0] win_pos_q, win_pos_d;
   logic [MW-1:0]   max_mag_q, max_mag_d;
   logic [DW-1:0]   max_i_q, max_i_d;
   logic [DW-1:0]   max_qv_q, max_qv_d;
   logic [IDXW-1:0] max_idx_q, max_idx_d;

   logic            out_valid_q, out_valid_d;
   logic [MW-1:0]   out_mag_q, out_mag_d;
   logic [DW-1:0]   out_i_q, out_i_d;
   logic [DW-1:0]   out_qv_q, out_qv_d;
   logic [IDXW-1:0] out_idx_q, out_idx_d;
`ifdef WINDOW_PEAK_THRESH_EN
   logic            out_hit_q, out_hit_d;
`endif

   logic            take_new;
   logic [MW-1:0]   cand_mag;
   logic [DW-1:0]   cand_i;
   logic [DW-1:0]   cand_qv;
   logic [IDXW-1:0] cand_idx;

   // Running max including the current sample; index 0 always loads, later ones need a strict win
   always_comb begin
      take_new = (win_pos_q == '0) || (in_mag > max_mag_q);
      cand_mag = take_new ? in_mag    : max_mag_q;
      cand_i   = take_new ? in_i      : max_i_q;
      cand_qv  = take_new ? in_q      : max_qv_q;
      cand_idx = take_new ? win_pos_q : max_idx_q;
   end

   always_comb begin
      win_pos_d   = win_pos_q;
      max_mag_d   = max_mag_q;
      max_i_d     = max_i_q;
      max_qv_d    = max_qv_q;
      max_idx_d   = max_idx_q;
      out_valid_d = 1'b0;
      out_mag_d   = out_mag_q;
      out_i_d     = out_i_q;
      out_qv_d    = out_qv_q;
      out_idx_d   = out_idx_q;
`ifdef WINDOW_PEAK_THRESH_EN
      out_hit_d   = out_hit_q;
`endif
      if (restart) begin
         // Restart wins over window completion; a coincident sample opens the new window
         win_pos_d = '0;
         if (in_valid) begin
            win_pos_d = AFTER_RST;
            max_mag_d = in_mag;
            max_i_d   = in_i;
            max_qv_d  = in_q;
            max_idx_d = '0;
         end
      end else if (in_valid) begin
         max_mag_d = cand_mag;
         max_i_d   = cand_i;
         max_qv_d  = cand_qv;
         max_idx_d = cand_idx;
         if (win_pos_q == LAST_IDX) begin
            win_pos_d   = '0;
            out_valid_d = 1'b1;
            out_mag_d   = cand_mag;
            out_i_d     = cand_i;
            out_qv_d    = cand_qv;
            out_idx_d   = cand_idx;
`ifdef WINDOW_PEAK_THRESH_EN
            out_hit_d   = (cand_mag >= thresh);
`endif
         end else begin
            win_pos_d = win_pos_q + IDXW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_pos_q   <= '0;
         max_mag_q   <= '0;
         max_i_q     <= '0;
         max_qv_q    <= '0;
         max_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_mag_q   <= '0;
         out_i_q     <= '0;
         out_qv_q    <= '0;
         out_idx_q   <= '0;
`ifdef WINDOW_PEAK_THRESH_EN
         out_hit_q   <= 1'b0;
`endif
      end else begin
         win_pos_q   <= win_pos_d;
         max_mag_q   <= max_mag_d;
         max_i_q     <= max_i_d;
         max_qv_q    <= max_qv_d;
         max_idx_q   <= max_idx_d;
         out_valid_q <= out_valid_d;
         out_mag_q   <= out_mag_d;
         out_i_q     <= out_i_d;
         out_qv_q    <= out_qv_d;
         out_idx_q   <= out_idx_d;
`ifdef WINDOW_PEAK_THRESH_EN
         out_hit_q   <= out_hit_d;
`endif
      end
   end

   assign win_pos   = win_pos_q;
   assign out_valid = out_valid_q;
   assign out_mag   = out_mag_q;
   assign out_i     = out_i_q;
   assign out_q     = out_qv_q;
   assign out_idx   = out_idx_q;
`ifdef WINDOW_PEAK_THRESH_EN
   assign out_hit   = out_hit_q;
`endif

endmodule

// File: tb/tb_window_peak_detector.sv
// Randomized and directed bench for window_peak_detector (WIN=4) against a queue-based window model.
module tb_window_peak_detector;

   localparam int unsigned DW   = 16;
   localparam int unsigned MW   = 33;
   localparam int unsigned WIN  = 4;
   localparam int unsigned IDXW = 5;

   logic            clk = 1'b0;
   logic            reset, in_valid, restart;
   logic [MW-1:0]   in_mag;
   logic [DW-1:0]   in_i, in_q;
   logic            out_valid;
   logic [MW-1:0]   out_mag;
   logic [DW-1:0]   out_i, out_q;
   logic [IDXW-1:0] out_idx, win_pos;
`ifdef WINDOW_PEAK_THRESH_EN
   logic [MW-1:0]   thresh;
   logic            out_hit;
   logic            exp_hit;
`endif

   always #5 clk = ~clk;

   window_peak_detector #(.DW(DW), .MW(MW), .WIN(WIN), .IDXW(IDXW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_mag(in_mag),
      .in_i(in_i), .in_q(in_q), .restart(restart), .out_valid(out_valid),
      .out_mag(out_mag), .out_i(out_i), .out_q(out_q), .out_idx(out_idx),
      .win_pos(win_pos)
`ifdef WINDOW_PEAK_THRESH_EN
      , .thresh(thresh), .out_hit(out_hit)
`endif
   );

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Model: samples of the open window, plus the expected output registers
   logic [MW-1:0] wm[$];
   logic [DW-1:0] wi[$];
   logic [DW-1:0] wq[$];
   logic          exp_valid;
   logic [MW-1:0] exp_mag;
   logic [DW-1:0] exp_i, exp_q;
   int            exp_idx;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input bit rst, input bit rs, input bit v, input logic [MW-1:0] m,
                               input logic [DW-1:0] i, input logic [DW-1:0] q);
      int best;
      exp_valid = 1'b0;
      if (rst) begin
         wm.delete(); wi.delete(); wq.delete();
         exp_mag = '0; exp_i = '0; exp_q = '0; exp_idx = 0;
`ifdef WINDOW_PEAK_THRESH_EN
         exp_hit = 1'b0;
`endif
      end else if (rs) begin
         wm.delete(); wi.delete(); wq.delete();
         if (v) begin wm.push_back(m); wi.push_back(i); wq.push_back(q); end
      end else if (v) begin
         wm.push_back(m); wi.push_back(i); wq.push_back(q);
         if (wm.size() == WIN) begin
            best = 0;
            for (int j = 1; j < wm.size(); j++)
               if (wm[j] > wm[best]) best = j;
            exp_valid = 1'b1;
            exp_mag = wm[best]; exp_i = wi[best]; exp_q = wq[best]; exp_idx = best;
`ifdef WINDOW_PEAK_THRESH_EN
            exp_hit = (wm[best] >= thresh);
`endif
            wm.delete(); wi.delete(); wq.delete();
         end
      end
   endtask

   task automatic step(input bit rst, input bit rs, input bit v, input logic [MW-1:0] m);
      logic [DW-1:0] i, q;
      i = DW'($urandom);
      q = DW'($urandom);
      reset = rst; restart = rs; in_valid = v; in_mag = m; in_i = i; in_q = q;
      @(posedge clk);
      model_update(rst, rs, v, m, i, q);
      #1;
      if (out_valid === 1'b1) pulses++;
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("win_pos",   64'(win_pos),   64'(wm.size() % WIN));
      check("out_mag",   64'(out_mag),   64'(exp_mag));
      check("out_i",     64'(out_i),     64'(exp_i));
      check("out_q",     64'(out_q),     64'(exp_q));
      check("out_idx",   64'(out_idx),   64'(exp_idx));
`ifdef WINDOW_PEAK_THRESH_EN
      check("out_hit",   64'(out_hit),   64'(exp_hit));
`endif
   endtask

   task automatic samp(input logic [MW-1:0] m);
      step(1'b0, 1'b0, 1'b1, m);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [MW-1:0] m;
      reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_mag = '0; in_i = '0; in_q = '0;
      exp_valid = 1'b0; exp_mag = '0; exp_i = '0; exp_q = '0; exp_idx = 0;
`ifdef WINDOW_PEAK_THRESH_EN
      thresh = MW'(9);
      exp_hit = 1'b0;
`endif
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b1, MW'(77));

      // Basic peak, tie handling, restart mid-window
      samp(5); samp(9); samp(3); samp(7); idle();
      samp(6); samp(6); samp(2); samp(6); idle(); idle();
      samp(1); samp(8); step(1'b0, 1'b1, 1'b1, MW'(4)); samp(2); samp(3); samp(1); idle();

      // 12 samples with 0-3 idle cycles between them
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         samp(MW'($urandom_range(0, 15)));
         for (int g = $urandom_range(0, 3); g > 0; g--) idle();
      end
      idle();
      check("pulses_12", 64'(pulses), 64'(3));

      // Reset mid-window, then a fresh window
      pulses = 0;
      samp(20); samp(30); step(1'b1, 1'b0, 1'b0, '0);
      check("pulses_rst", 64'(pulses), 64'(0));
      samp(3); samp(1); samp(4); samp(2); idle();

`ifdef WINDOW_PEAK_THRESH_EN
      samp(1); samp(9); samp(2); samp(3); idle();
      check("hit_9", 64'(out_hit), 64'(1));
      samp(8); samp(0); samp(1); samp(2); idle();
      check("hit_8", 64'(out_hit), 64'(0));
`endif

      // Random traffic with occasional restarts and resets
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) m = {1'b1, 32'($urandom)};
         else                           m = MW'($urandom_range(0, 31));
`ifdef WINDOW_PEAK_THRESH_EN
         thresh = MW'($urandom_range(0, 31));
`endif
         step($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 9) < 7, m);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
